// File: rtl/rev_pkg.sv
// rev_pkg: shared defaults and FSM state type for the revolution gate counter.
package rev_pkg;
    localparam int CNT_W_DEF = 16;
    localparam int DB_CYCLES_DEF = 16;
    typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/rev_gate_counter_if.sv
// rev_gate_counter_if: gate/sensor inputs and published count outputs.
interface rev_gate_counter_if #(parameter int CNT_W = rev_pkg::CNT_W_DEF);
    logic gate_in;
    logic sensor_in;
    logic [CNT_W-1:0] rev_count;
    logic count_valid;
    logic overflow;
    modport master(output gate_in, sensor_in, input rev_count, count_valid, overflow);
    modport slave(input gate_in, sensor_in, output rev_count, count_valid, overflow);
endinterface

// File: rtl/rev_debounce.sv
// rev_debounce: accepts a new level only after DB_CYCLES consecutive cycles of it.
module rev_debounce #(parameter int DB_CYCLES = rev_pkg::DB_CYCLES_DEF) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);
    localparam int W = $clog2(DB_CYCLES + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt <= '0;
            dout <= 1'b0;
        end else if (din == dout) begin
            cnt <= '0;
        end else if (cnt == W'(DB_CYCLES - 1)) begin
            dout <= din;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
endmodule

// File: rtl/rev_gate_counter.sv
// rev_gate_counter: counts sensor revolutions per gate half-period and publishes each window.
// Define REV_DEBOUNCE_EN to insert rev_debounce after the synchroniser.
module rev_gate_counter
    import rev_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input logic clk,
    input logic rst_n,
    rev_gate_counter_if.slave bus
);
    logic [1:0] sync;
    logic sens, sens_q, gate_q, rev, bnd, sticky;
    logic [CNT_W-1:0] cnt;
    state_t state;
`ifdef REV_DEBOUNCE_EN
    rev_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (.clk(clk), .rst_n(rst_n), .din(sync[1]), .dout(sens));
`else
    assign sens = sync[1];
`endif
    assign rev = sens & ~sens_q;
    assign bnd = bus.gate_in ^ gate_q;
    // A revolution coinciding with a boundary belongs to the new window.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sync <= '0;
            sens_q <= 1'b0;
            gate_q <= 1'b0;
            cnt <= '0;
            sticky <= 1'b0;
            state <= IDLE;
            bus.rev_count <= '0;
            bus.count_valid <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            sync <= {sync[0], bus.sensor_in};
            sens_q <= sens;
            gate_q <= bus.gate_in;
            bus.count_valid <= 1'b0;
            if (bnd) begin
                cnt <= CNT_W'(rev);
                sticky <= 1'b0;
                state <= RUN;
                if (state == RUN) begin
                    bus.rev_count <= cnt;
                    bus.overflow <= sticky;
                    bus.count_valid <= 1'b1;
                end
            end else if (state == RUN && rev) begin
                if (&cnt) sticky <= 1'b1;
                else cnt <= cnt + 1'b1;
            end
        end
endmodule

// File: tb/tb_rev_gate_counter.sv
// tb_rev_gate_counter: directed bench driving a 16-bit and a 4-bit counter from one stimulus.
module tb_rev_gate_counter;
    import rev_pkg::*;
`ifdef REV_DEBOUNCE_EN
    localparam int LAT = 18;
    localparam int GL = 4;
`else
    localparam int LAT = 2;
    localparam int GL = 7;
`endif
    logic clk = 1'b0;
    logic rst_n;
    int npass = 0;
    int nfail = 0;
    int ntot = 0;
    int ncv = 0;
    int snap;
    always #5 clk = ~clk;
    rev_gate_counter_if #(.CNT_W(16)) ba ();
    rev_gate_counter_if #(.CNT_W(4)) bb ();
    assign bb.gate_in = ba.gate_in;
    assign bb.sensor_in = ba.sensor_in;
    rev_gate_counter #(.CNT_W(16), .DB_CYCLES(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ba));
    rev_gate_counter #(.CNT_W(4), .DB_CYCLES(16)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bb));
    always @(negedge clk) if (ba.count_valid === 1'b1) ncv++;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic pulse(input int hi, input int lo);
        ba.sensor_in = 1'b1;
        step(hi);
        ba.sensor_in = 1'b0;
        step(lo);
    endtask
    task automatic chk_out(input string tag, input logic cv, input int ea, input int eb, input logic ob);
        chk({tag, "_cv_a"}, 32'(ba.count_valid), 32'(cv));
        chk({tag, "_cv_b"}, 32'(bb.count_valid), 32'(cv));
        chk({tag, "_cnt_a"}, 32'(ba.rev_count), ea);
        chk({tag, "_ovf_a"}, 32'(ba.overflow), 0);
        chk({tag, "_cnt_b"}, 32'(bb.rev_count), eb);
        chk({tag, "_ovf_b"}, 32'(bb.overflow), 32'(ob));
    endtask
    task automatic boundary(input string tag, input logic cv, input int ea, input int eb, input logic ob);
        ba.gate_in = ~ba.gate_in;
        step(1);
        chk_out(tag, cv, ea, eb, ob);
        step(1);
        chk_out({tag, "_hold"}, 1'b0, ea, eb, ob);
    endtask
    task automatic win(input string tag, input int n, input int ea, input int eb, input logic ob);
        for (int i = 0; i < n; i++) pulse(40, 40);
        if (1000 - 80 * n - 2 > 0) step(1000 - 80 * n - 2);
        boundary(tag, 1'b1, ea, eb, ob);
    endtask
    initial begin
        rst_n = 1'b0;
        ba.gate_in = 1'b1;
        ba.sensor_in = 1'b0;
        step(3);
        chk_out("reset", 1'b0, 0, 0, 1'b0);
        rst_n = 1'b1;
        step(1);
        chk_out("first_bnd", 1'b0, 0, 0, 1'b0);
        step(1);
        chk("first_bnd_nocv", 32'(ncv), 0);
        win("w7a", 7, 7, 7, 1'b0);
        win("w7b", 7, 7, 7, 1'b0);
        win("w20", 20, 20, 15, 1'b1);
        win("w3", 3, 3, 3, 1'b0);
        win("z0", 0, 0, 0, 1'b0);
        win("z1", 0, 0, 0, 1'b0);
        win("z2", 0, 0, 0, 1'b0);
        ba.sensor_in = 1'b1;
        step(LAT);
        boundary("align", 1'b1, 0, 0, 1'b0);
        step(38);
        ba.sensor_in = 1'b0;
        step(40);
        pulse(40, 40);
        step(700);
        boundary("align_next", 1'b1, 2, 2, 1'b0);
        for (int i = 0; i < 3; i++) pulse(5, 40);
        for (int i = 0; i < 4; i++) pulse(40, 40);
        step(500);
        boundary("glitch", 1'b1, GL, GL, 1'b0);
        for (int i = 0; i < 5; i++) pulse(40, 40);
        snap = ncv;
        rst_n = 1'b0;
        ba.gate_in = 1'b0;
        step(1);
        chk_out("mid_rst", 1'b0, 0, 0, 1'b0);
        step(2);
        rst_n = 1'b1;
        pulse(40, 40);
        pulse(40, 40);
        chk("mid_rst_nocv", 32'(ncv), 32'(snap));
        boundary("post_rst_bnd", 1'b0, 0, 0, 1'b0);
        chk("post_rst_nocv", 32'(ncv), 32'(snap));
        win("post_rst_win", 2, 2, 2, 1'b0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/rev_gate_counter.md
REV_GATE_COUNTER -- requirements
Module: rev_gate_counter

Interface
REQ-001 Parameter CNT_W, default 16, width of the revolution count and the published count.
REQ-002 Parameter DB_CYCLES, default 16, number of consecutive stable clk cycles the debouncer requires before accepting a new sensor level.
REQ-003 Port clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port gate_in  input  1  gate square wave from the 100 ms divider, synchronous to clk; every edge, rising or falling, marks a window boundary.
REQ-006 Port sensor_in  input  1  raw revolution sensor pulse, asynchronous to clk.
REQ-007 Port rev_count  output  CNT_W  revolutions counted in the last complete window.
REQ-008 Port count_valid  output  1  one-cycle strobe: rev_count was updated this cycle.
REQ-009 Port overflow  output  1  the last complete window saturated the counter.

Function
REQ-010 sensor_in shall pass through a 2-flop synchroniser before any other use.
REQ-011 A revolution shall be one rising edge of the conditioned sensor level, detected against a registered copy of that level.
REQ-012 A window boundary shall be detected as gate_in differing from its registered copy, giving 1 cycle of detection latency.
REQ-013 The FSM shall have two states, IDLE and RUN; the reset state is IDLE.
REQ-014 IDLE: no count is published; on the first boundary, go to RUN and clear the counter, discarding the partial window.
REQ-015 RUN: each revolution increments the counter; the counter saturates at 2^CNT_W-1, and further edges set an internal sticky overflow bit.
REQ-016 RUN boundary: in the same cycle, load rev_count with the counter, load overflow with the sticky bit, pulse count_valid for exactly 1 cycle, and clear the counter and sticky bit.
REQ-017 Revolution and boundary in the same cycle: the revolution goes to the new window, so the counter restarts at 1 and the published value excludes it.
REQ-018 rev_count and overflow shall hold their values between boundaries.
REQ-019 count_valid shall be registered; it asserts the cycle after the boundary-detect flop sees the change.
REQ-020 The sensor-edge-to-counter-increment latency shall be fixed (sync plus conditioning plus 1) and identical for every edge.

Reset
REQ-021 When rst_n is low: rev_count=0, count_valid=0, overflow=0, counter=0, sticky bit=0, FSM=IDLE, and synchroniser and debounce flops=0.
REQ-022 The gate_in history flop shall reset to 0, so a gate_in high at release is detected as a boundary that only moves IDLE to RUN.
REQ-023 Reset asserted mid-window shall discard all in-progress counts, and no count_valid is generated by the reset.

Configuration
REQ-024 Macro REV_DEBOUNCE_EN defined: the synchronised sensor feeds the debouncer, which updates its output only after DB_CYCLES consecutive cycles of a new level; glitches shorter than DB_CYCLES are never counted.
REQ-025 REV_DEBOUNCE_EN undefined: the synchronised sensor is used directly, the debouncer is not instantiated, DB_CYCLES is ignored, and the latency is 2 cycles shorter-path.

Structure
REQ-026 Package rev_pkg shall hold the CNT_W default, DB_CYCLES default, and the FSM state enum (IDLE, RUN).
REQ-027 One sub-module, rev_debounce (parameter DB_CYCLES, ports clk, rst_n, din, dout), is instantiated only under REV_DEBOUNCE_EN.

Verification
REQ-028 Reset release, then gate_in toggles every 1000 cycles with 7 clean sensor pulses per window -> the first boundary gives no count_valid; each later boundary gives count_valid=1 for 1 cycle, rev_count=7, overflow=0.
REQ-029 CNT_W=4 with 20 pulses in one window -> rev_count=15, overflow=1; the next window with 3 pulses -> rev_count=3, overflow=0.
REQ-030 A sensor rising edge aligned to arrive at the counter in the boundary cycle -> published count excludes it, and the next window includes it.
REQ-031 REV_DEBOUNCE_EN defined, DB_CYCLES=16, with 5-cycle glitches plus 4 pulses of 40-cycle width -> rev_count=4; with the macro undefined, the same stimulus counts the glitches.
REQ-032 rst_n low for 3 cycles mid-window after 5 pulses -> outputs read 0 and there is no count_valid; the window after reset is discarded per REQ-014.
REQ-033 No sensor pulses across 3 windows -> count_valid pulses each boundary with rev_count=0.
